sprite_mover: RTL and testbench

Parametrised animated-rectangle engine for the VGA adapter path. It draws a W×H solid rectangle at a latched start position, holds it for a programmable number of frames, erases it with the background colour, then moves one pixel in a selectable direction. At screen edges it either wraps or bounces. It generalises the fixed 40×10, vertical-only staircase animator and streams pixels one per cycle on the same out_x/out_y/out_colour/plot interface that feeds the VGA adapter.

---
 rtl/sprite_mover_if.sv | 19 +
 rtl/sprite_mover.sv | 222 ++++++++++++++++++++++
 tb/tb_sprite_mover.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_mover_if.sv
// ----------------------------------------------------------------------------
// sprite_mover_if
// Pixel-stream bus between the sprite engine and the VGA adapter.
//   out_x      : pixel x coordinate
//   out_y      : pixel y coordinate
//   out_colour : pixel colour
//   plot       : pixel write strobe, one pixel per cycle while high
// The master (sprite_mover) drives all four signals from registers; the
// slave (VGA adapter or a testbench) only observes them.
// ----------------------------------------------------------------------------
interface sprite_mover_if;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] out_colour;
    logic       plot;

    modport master (output out_x, output out_y, output out_colour, output plot);
    modport slave  (input  out_x, input  out_y, input  out_colour, input  plot);
endinterface

// File: rtl/sprite_mover.sv
// ----------------------------------------------------------------------------
// sprite_mover
// Animated-rectangle engine: draws a W x H solid rectangle at a latched start
// position, holds it for FRAMES frame ticks of DELAY cycles each, erases it
// with BG_COLOUR, then moves one pixel in the current direction. At the
// screen edges the sprite either wraps (WRAP=1) or bounces (WRAP=0).
//
// Ports:
//   clock      : system clock
//   reset      : synchronous, active-high reset
//   go         : start animation (sampled only in IDLE)
//   halt       : stop after the current hold (sampled only in WAIT)
//   in_x/in_y  : start position, clamped so the sprite stays on screen
//   colour     : sprite colour, latched on go
//   dir        : start direction, 00 up, 01 down, 10 left, 11 right
//   pix        : registered pixel stream (out_x, out_y, out_colour, plot)
//   busy       : high while the engine is active (registered)
//   cur_dir    : current direction including bounce reversals
//   step_count : moves completed since the last go, modulo 256
// ----------------------------------------------------------------------------
module sprite_mover #(
    parameter int         W         = 40,
    parameter int         H         = 10,
    parameter int         SCREEN_W  = 160,
    parameter int         SCREEN_H  = 120,
    parameter int         DELAY     = 833333,
    parameter int         FRAMES    = 15,
    parameter logic [2:0] BG_COLOUR = 3'b111,
    parameter bit         WRAP      = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  halt,
    input  logic [7:0]            in_x,
    input  logic [6:0]            in_y,
    input  logic [2:0]            colour,
    input  logic [1:0]            dir,
    sprite_mover_if.master        pix,
    output logic                  busy,
    output logic [1:0]            cur_dir,
    output logic [7:0]            step_count
);

    localparam logic [7:0] X_MAX   = 8'(SCREEN_W - W);
    localparam logic [6:0] Y_MAX   = 7'(SCREEN_H - H);
    localparam logic [7:0] CX_LAST = 8'(W - 1);
    localparam logic [6:0] CY_LAST = 7'(H - 1);

    localparam int DLY_W = $clog2(DELAY + 1);
    localparam int FRM_W = $clog2(FRAMES + 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAMES - 1);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_WAIT,
        S_ERASE,
        S_MOVE
    } state_t;

    state_t             state, next_state;
    logic [7:0]         pos_x;
    logic [6:0]         pos_y;
    logic [2:0]         spr_colour;
    logic [7:0]         cx;
    logic [6:0]         cy;
    logic [DLY_W-1:0]   delay_cnt;
    logic [FRM_W-1:0]   frame_cnt;

    logic               scan_last;
    logic               hold_last;
    logic [7:0]         mv_x;
    logic [6:0]         mv_y;
    logic [1:0]         mv_dir;

    assign scan_last = (cx == CX_LAST) && (cy == CY_LAST);
    assign hold_last = (delay_cnt == DLY_LAST) && (frame_cnt == FRM_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:  if (go) next_state = S_DRAW;
            S_DRAW:  if (scan_last) next_state = S_WAIT;
            S_WAIT: begin
                // halt takes priority over the end of the hold: the sprite
                // stays drawn.
                if (halt)           next_state = S_IDLE;
                else if (hold_last) next_state = S_ERASE;
            end
            S_ERASE: if (scan_last) next_state = S_MOVE;
            S_MOVE:  next_state = S_DRAW;
            default: next_state = S_IDLE;
        endcase
    end

    // One-pixel move. At an edge the sprite either wraps to the opposite
    // edge or reverses and steps away; with a zero-length axis the bounce
    // leaves the position unchanged.
    always_comb begin
        mv_x   = pos_x;
        mv_y   = pos_y;
        mv_dir = cur_dir;
        case (cur_dir)
            DIR_UP: begin
                if (pos_y != 7'd0)    mv_y = pos_y - 7'd1;
                else if (WRAP)        mv_y = Y_MAX;
                else begin
                    mv_dir = DIR_DOWN;
                    if (Y_MAX != 7'd0) mv_y = 7'd1;
                end
            end
            DIR_DOWN: begin
                if (pos_y != Y_MAX)   mv_y = pos_y + 7'd1;
                else if (WRAP)        mv_y = 7'd0;
                else begin
                    mv_dir = DIR_UP;
                    if (Y_MAX != 7'd0) mv_y = Y_MAX - 7'd1;
                end
            end
            DIR_LEFT: begin
                if (pos_x != 8'd0)    mv_x = pos_x - 8'd1;
                else if (WRAP)        mv_x = X_MAX;
                else begin
                    mv_dir = DIR_RIGHT;
                    if (X_MAX != 8'd0) mv_x = 8'd1;
                end
            end
            default: begin
                if (pos_x != X_MAX)   mv_x = pos_x + 8'd1;
                else if (WRAP)        mv_x = 8'd0;
                else begin
                    mv_dir = DIR_LEFT;
                    if (X_MAX != 8'd0) mv_x = X_MAX - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pos_x          <= 8'd0;
            pos_y          <= 7'd0;
            spr_colour     <= 3'd0;
            cx             <= 8'd0;
            cy             <= 7'd0;
            delay_cnt      <= '0;
            frame_cnt      <= '0;
            cur_dir        <= DIR_UP;
            step_count     <= 8'd0;
            busy           <= 1'b0;
            pix.out_x      <= 8'd0;
            pix.out_y      <= 7'd0;
            pix.out_colour <= BG_COLOUR;
            pix.plot       <= 1'b0;
        end else begin
            // busy is registered like the pixel outputs, so it rises with the
            // first plotted pixel and falls one edge after leaving WAIT.
            busy     <= (state != S_IDLE);
            pix.plot <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        pos_x      <= (in_x > X_MAX) ? X_MAX : in_x;
                        pos_y      <= (in_y > Y_MAX) ? Y_MAX : in_y;
                        spr_colour <= colour;
                        cur_dir    <= dir;
                        step_count <= 8'd0;
                        cx         <= 8'd0;
                        cy         <= 7'd0;
                    end
                end
                S_DRAW, S_ERASE: begin
                    pix.out_x      <= pos_x + cx;
                    pix.out_y      <= pos_y + cy;
                    pix.out_colour <= (state == S_DRAW) ? spr_colour : BG_COLOUR;
                    pix.plot       <= 1'b1;
                    if (cx == CX_LAST) begin
                        cx <= 8'd0;
                        cy <= (cy == CY_LAST) ? 7'd0 : cy + 7'd1;
                    end else begin
                        cx <= cx + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (halt) begin
                        delay_cnt <= '0;
                        frame_cnt <= '0;
                    end else if (delay_cnt == DLY_LAST) begin
                        delay_cnt <= '0;
                        frame_cnt <= (frame_cnt == FRM_LAST) ? '0 : frame_cnt + 1'b1;
                    end else begin
                        delay_cnt <= delay_cnt + 1'b1;
                    end
                end
                S_MOVE: begin
                    pos_x      <= mv_x;
                    pos_y      <= mv_y;
                    cur_dir    <= mv_dir;
                    step_count <= step_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_mover.sv
// ----------------------------------------------------------------------------
// tb_sprite_mover
// Drives two sprite_mover instances (WRAP=1 and WRAP=0) with identical
// stimulus. For every animation run the bench first builds the expected
// per-cycle output trace from the animation rules (draw pass, hold, erase
// pass, one-pixel move), then replays random stimulus and compares each
// cycle's outputs against the trace.
// ----------------------------------------------------------------------------
module tb_sprite_mover;

    localparam int W      = 4;
    localparam int H      = 2;
    localparam int SW     = 8;
    localparam int SH     = 6;
    localparam int DELAY  = 3;
    localparam int FRAMES = 2;
    localparam int XMAX   = SW - W;
    localparam int YMAX   = SH - H;
    localparam int WH     = W * H;
    localparam int DF     = DELAY * FRAMES;
    localparam int BG     = 7;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       go    = 1'b0;
    logic       halt  = 1'b0;
    logic [7:0] in_x  = 8'd0;
    logic [6:0] in_y  = 7'd0;
    logic [2:0] colour = 3'd0;
    logic [1:0] dir   = 2'd0;

    logic       busy0, busy1;
    logic [1:0] cd0, cd1;
    logic [7:0] sc0, sc1;

    sprite_mover_if p0();
    sprite_mover_if p1();

    sprite_mover #(
        .W(W), .H(H), .SCREEN_W(SW), .SCREEN_H(SH), .DELAY(DELAY),
        .FRAMES(FRAMES), .BG_COLOUR(3'b111), .WRAP(1'b1)
    ) dut_wrap (
        .clock(clock), .reset(reset), .go(go), .halt(halt),
        .in_x(in_x), .in_y(in_y), .colour(colour), .dir(dir),
        .pix(p0), .busy(busy0), .cur_dir(cd0), .step_count(sc0)
    );

    sprite_mover #(
        .W(W), .H(H), .SCREEN_W(SW), .SCREEN_H(SH), .DELAY(DELAY),
        .FRAMES(FRAMES), .BG_COLOUR(3'b111), .WRAP(1'b0)
    ) dut_bounce (
        .clock(clock), .reset(reset), .go(go), .halt(halt),
        .in_x(in_x), .in_y(in_y), .colour(colour), .dir(dir),
        .pix(p1), .busy(busy1), .cur_dir(cd1), .step_count(sc1)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit plot;
        bit busy;
        int x;
        int y;
        int c;
        int d;
        int sc;
        bit go_ok;      // go may be randomised on the edge producing this entry
        bit halt_ok;    // halt may be randomised on that edge
        bit halt_edge;  // halt is forced high on that edge
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   g_x, g_y, g_c, g_d;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input bit plot, input bit busy, input int x, input int y,
                                input int c, input int d, input int sc,
                                input bit go_ok, input bit halt_ok, input bit halt_edge);
        exp_t e;
        e.plot = plot; e.busy = busy; e.x = x; e.y = y; e.c = c; e.d = d; e.sc = sc;
        e.go_ok = go_ok; e.halt_ok = halt_ok; e.halt_edge = halt_edge;
        return e;
    endfunction

    task automatic add(input bit wrap, input exp_t e);
        if (wrap) q0.push_back(e);
        else      q1.push_back(e);
    endtask

    // Reference move: signed step, then resolve leaving the range [0, lim].
    task automatic model_move(input bit wrap, inout int x, inout int y, inout int d);
        int p, lim, stp, np;
        if (d >= 2) begin p = x; lim = XMAX; stp = (d == 3) ? 1 : -1; end
        else        begin p = y; lim = YMAX; stp = (d == 1) ? 1 : -1; end
        np = p + stp;
        if (np < 0 || np > lim) begin
            if (wrap) np = (np < 0) ? lim : 0;
            else begin
                d  = d ^ 1;
                np = p - stp;
                if (np < 0)   np = 0;
                if (np > lim) np = lim;
            end
        end
        if (d >= 2) x = np;
        else        y = np;
    endtask

    task automatic pass(input bit wrap, input int x, input int y, input int c, input int d, input int sc);
        for (int i = 0; i < WH; i++)
            add(wrap, mk(1, 1, x + i % W, y + i / W, c, d, sc, 1, 1, 0));
    endtask

    // Trace: go edge, nsteps full periods, one more draw, halt on the
    // halt_m-th WAIT edge, then one idle cycle with busy low.
    task automatic build(input bit wrap, input int nsteps, input int halt_m);
        int x, y, d, sc;
        x  = (g_x > XMAX) ? XMAX : g_x;
        y  = (g_y > YMAX) ? YMAX : g_y;
        d  = g_d;
        sc = 0;
        add(wrap, mk(0, 0, 0, 0, 0, d, sc, 0, 1, 0));
        for (int s = 0; s < nsteps; s++) begin
            pass(wrap, x, y, g_c, d, sc);
            for (int i = 0; i < DF; i++) add(wrap, mk(0, 1, 0, 0, 0, d, sc, 1, 0, 0));
            pass(wrap, x, y, BG, d, sc);
            model_move(wrap, x, y, d);
            sc = (sc + 1) % 256;
            add(wrap, mk(0, 1, 0, 0, 0, d, sc, 1, 1, 0));
        end
        pass(wrap, x, y, g_c, d, sc);
        for (int m = 1; m <= halt_m; m++) add(wrap, mk(0, 1, 0, 0, 0, d, sc, 1, 0, m == halt_m));
        add(wrap, mk(0, 0, 0, 0, 0, d, sc, 0, 0, 0));
    endtask

    task automatic cmp(input int i, input int j, input exp_t e, input logic plot, input logic bsy,
                       input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                       input logic [1:0] d, input logic [7:0] sc);
        check($sformatf("dut%0d.plot[%0d]", i, j), 32'(plot), 32'(e.plot));
        check($sformatf("dut%0d.busy[%0d]", i, j), 32'(bsy), 32'(e.busy));
        check($sformatf("dut%0d.cur_dir[%0d]", i, j), 32'(d), 32'(e.d));
        check($sformatf("dut%0d.step_count[%0d]", i, j), 32'(sc), 32'(e.sc));
        if (e.plot) begin
            check($sformatf("dut%0d.x[%0d]", i, j), 32'(x), 32'(e.x));
            check($sformatf("dut%0d.y[%0d]", i, j), 32'(y), 32'(e.y));
            check($sformatf("dut%0d.colour[%0d]", i, j), 32'(c), 32'(e.c));
        end
    endtask

    // Drives the inputs for the edge producing entry j, then samples at the
    // following falling edge. Called from a falling edge.
    task automatic run(input int n);
        for (int j = 0; j < n; j++) begin
            in_x   = 8'($urandom);
            in_y   = 7'($urandom);
            colour = 3'($urandom);
            dir    = 2'($urandom);
            if (j == 0) begin
                go = 1'b1; in_x = 8'(g_x); in_y = 7'(g_y); colour = 3'(g_c); dir = 2'(g_d);
                halt = 1'($urandom);
            end else begin
                go   = q0[j].go_ok ? 1'($urandom) : 1'b0;
                halt = q0[j].halt_edge ? 1'b1 : (q0[j].halt_ok ? 1'($urandom) : 1'b0);
            end
            @(posedge clock);
            @(negedge clock);
            cmp(0, j, q0[j], p0.plot, busy0, p0.out_x, p0.out_y, p0.out_colour, cd0, sc0);
            cmp(1, j, q1[j], p1.plot, busy1, p1.out_x, p1.out_y, p1.out_colour, cd1, sc1);
        end
        go   = 1'b0;
        halt = 1'b0;
    endtask

    task automatic scenario(input int x, input int y, input int c, input int d,
                            input int nsteps, input int halt_m);
        g_x = x; g_y = y; g_c = c; g_d = d;
        q0.delete();
        q1.delete();
        build(1'b1, nsteps, halt_m);
        build(1'b0, nsteps, halt_m);
        run(q0.size());
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".plot0"}, 32'(p0.plot), 0);
        check({tag, ".x0"}, 32'(p0.out_x), 0);
        check({tag, ".y0"}, 32'(p0.out_y), 0);
        check({tag, ".colour0"}, 32'(p0.out_colour), BG);
        check({tag, ".busy0"}, 32'(busy0), 0);
        check({tag, ".dir0"}, 32'(cd0), 0);
        check({tag, ".steps0"}, 32'(sc0), 0);
        check({tag, ".plot1"}, 32'(p1.plot), 0);
        check({tag, ".colour1"}, 32'(p1.out_colour), BG);
        check({tag, ".busy1"}, 32'(busy1), 0);
        check({tag, ".dir1"}, 32'(cd1), 0);
        check({tag, ".steps1"}, 32'(sc1), 0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset("reset");
        reset = 1'b0;

        // Basic rightward run, then halt on the second hold cycle.
        scenario(1, 2, 3'b010, 3, 3, 2);
        // Clamp to (4,4), moving up through y=0 (wrap to 4 / bounce to 1).
        scenario(200, 100, 3'b101, 0, 6, DF);
        // Up at y=0 from the start.
        scenario(0, 0, 3'b011, 0, 1, 1);
        // Left at x=0 and right at x=4.
        scenario(0, 3, 3'b110, 2, 2, 3);
        scenario(4, 1, 3'b001, 3, 2, 4);
        // Down at the bottom edge.
        scenario(2, 4, 3'b100, 1, 2, 5);

        for (int r = 0; r < 8; r++)
            scenario(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 7)), int'($urandom_range(1, DF)));

        // step_count wraps modulo 256.
        scenario(3, 1, 3'b010, int'($urandom_range(0, 3)), 260, 1);

        // Reset on the third erase pixel of the first pass.
        g_x = 2; g_y = 3; g_c = 3'b011; g_d = 1;
        q0.delete();
        q1.delete();
        build(1'b1, 1, 1);
        build(1'b0, 1, 1);
        run(WH + DF + 3);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_reset("mid_erase_reset");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            @(negedge clock);
            check($sformatf("post_reset_plot[%0d]", i), 32'(p0.plot | p1.plot), 0);
            check($sformatf("post_reset_busy[%0d]", i), 32'(busy0 | busy1), 0);
        end

        // A fresh run after reset starts cleanly.
        scenario(1, 0, 3'b111, 3, 1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
